// File: rtl/axis_slave_fifo.sv
// AXI4-Stream sink with a first-word-fall-through FIFO, TLAST pass-through, fill level and packet-length check.
// Build option: define AXIS_SLAVE_STRB_MASK_EN to zero byte lanes whose TSTRB bit is low before storage.
module axis_slave_fifo #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH         = 16,
  parameter int C_PKT_LEN            = 0
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  input  logic                                pi_data_read,
  output logic                                po_mlp_data_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     po_mlp_data,
  output logic                                po_mlp_data_last,
  output logic [$clog2(C_FIFO_DEPTH):0]       po_fill_level,
  output logic                                po_pkt_err
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = C_S_AXIS_TDATA_WIDTH + 1;
  localparam int NB = C_S_AXIS_TDATA_WIDTH / 8;

  logic [DW-1:0] mem [C_FIFO_DEPTH];
  logic [DW-1:0] head_reg;
  logic [DW-1:0] wr_word;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] wdata_masked;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ready_en_reg;
  logic          full, push, pop;

`ifdef AXIS_SLAVE_STRB_MASK_EN
  for (genvar gi = 0; gi < NB; gi++) begin : g_strb_mask
    assign wdata_masked[gi*8 +: 8] = S_AXIS_TSTRB[gi] ? S_AXIS_TDATA[gi*8 +: 8] : 8'h00;
  end
`else
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;
  assign wdata_masked = S_AXIS_TDATA;
`endif

  assign wr_word = {S_AXIS_TLAST, wdata_masked};

  // ready_en_reg keeps TREADY low while reset is held without a path from any input
  assign full          = (count_reg == CW'(C_FIFO_DEPTH));
  assign S_AXIS_TREADY = ready_en_reg & ~full;
  assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop           = pi_data_read & po_mlp_data_valid;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Registered read looks ahead at the next head address; a write landing on that
  // address (empty FIFO, or last entry popped) is forwarded so latency stays one edge.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) mem[wr_ptr_reg] <= wr_word;
    head_reg <= (push && (wr_ptr_reg == rd_ptr_next)) ? wr_word : mem[rd_ptr_next];
  end

  assign po_mlp_data_valid = (count_reg != '0);
  assign po_mlp_data       = head_reg[C_S_AXIS_TDATA_WIDTH-1:0];
  assign po_mlp_data_last  = head_reg[DW-1];
  assign po_fill_level     = count_reg;

  if (C_PKT_LEN != 0) begin : g_len_chk
    localparam int BW = $clog2(C_PKT_LEN + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(C_PKT_LEN - 1);

    logic [BW-1:0] beat_cnt_reg, beat_cnt_next;
    logic          pkt_err_reg, pkt_err_next;

    always_comb begin
      beat_cnt_next = beat_cnt_reg;
      pkt_err_next  = 1'b0;
      if (push) begin
        // mismatch between TLAST and "this is the final expected beat"
        pkt_err_next = S_AXIS_TLAST ^ (beat_cnt_reg == LAST_IDX);
        if (S_AXIS_TLAST || pkt_err_next) beat_cnt_next = '0;
        else                              beat_cnt_next = beat_cnt_reg + BW'(1);
      end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
      if (!S_AXIS_ARESETN) begin
        beat_cnt_reg <= '0;
        pkt_err_reg  <= 1'b0;
      end else begin
        beat_cnt_reg <= beat_cnt_next;
        pkt_err_reg  <= pkt_err_next;
      end
    end

    assign po_pkt_err = pkt_err_reg;
  end else begin : g_no_len_chk
    assign po_pkt_err = 1'b0;
  end

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Directed bench for axis_slave_fifo: one instance with a 4-beat length check, one with it disabled.
module tb_axis_slave_fifo;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int FW = $clog2(D) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           aresetn, tvalid, tlast, rd;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;

  logic          tready, valid, last, pkt_err;
  logic [W-1:0]  data;
  logic [FW-1:0] fill;

  logic          tready_nl, valid_nl, last_nl, pkt_err_nl;
  logic [W-1:0]  data_nl;
  logic [FW-1:0] fill_nl;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];
  logic [14:0] tl_v, er_v;
  logic [31:0] exp_strb;
  logic [32:0] exp_word;

  axis_slave_fifo #(.C_S_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PKT_LEN(4)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(aresetn), .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .pi_data_read(rd), .po_mlp_data_valid(valid),
    .po_mlp_data(data), .po_mlp_data_last(last), .po_fill_level(fill),
    .po_pkt_err(pkt_err)
  );

  axis_slave_fifo #(.C_S_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PKT_LEN(0)) dut_nl (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(aresetn), .S_AXIS_TREADY(tready_nl),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .pi_data_read(rd), .po_mlp_data_valid(valid_nl),
    .po_mlp_data(data_nl), .po_mlp_data_last(last_nl), .po_fill_level(fill_nl),
    .po_pkt_err(pkt_err_nl)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
    exp_q.push_back({l, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b0; tvalid = 1'b0; tlast = 1'b0; rd = 1'b0;
    tdata = '0; tstrb = '1;
    tl_v = 15'h4048;
    er_v = 15'h0440;

    // reset then idle
    repeat (3) step();
    check("tready_in_reset", tready, 0);
    aresetn = 1'b1;
    step();
    check("rst_tready", tready, 1);
    check("rst_valid", valid, 0);
    check("rst_fill", fill, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_valid_nl", valid_nl, 0);

    // fill to full with 0x00..0x0F, TLAST every 4th beat
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1;
      tdata  = 32'(i);
      tlast  = (i % 4) == 3;
      step();
      check("fill_level", fill, i + 1);
      check("fill_pkt_err", pkt_err, 0);
    end
    tdata = 32'h99;
    tlast = 1'b0;
    step();
    check("full_tready", tready, 0);
    check("full_no_push", fill, 16);
    check("full_head", data, 32'h00);
    check("full_valid", valid, 1);

    // pop while full with TVALID held: no push this cycle, ready next cycle
    tdata = 32'h10;
    rd    = 1'b1;
    step();
    rd = 1'b0;
    check("fullpop_fill", fill, 15);
    check("fullpop_tready", tready, 1);
    check("fullpop_head", data, 32'h01);
    step();
    tvalid = 1'b0;
    check("refill_fill", fill, 16);
    check("refill_tready", tready, 0);

    // pop down to 8 entries
    for (int k = 0; k < 8; k++) begin
      check("pop_data", data, 32'(1 + k));
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    check("pop_fill8", fill, 8);

    // simultaneous push/pop for 10 cycles, pointers wrap past 15
    for (int k = 0; k < 10; k++) begin
      check("sim_head", data, 32'(9 + k));
      tvalid = 1'b1;
      tdata  = 32'(17 + k);
      tlast  = ((17 + k) % 4) == 3;
      rd     = 1'b1;
      step();
      check("sim_fill", fill, 8);
      check("sim_pkt_err", pkt_err, 0);
    end
    tvalid = 1'b0; tlast = 1'b0; rd = 1'b0;

    // drain 0x13..0x1A
    for (int k = 0; k < 8; k++) begin
      check("drain_data", data, 32'(19 + k));
      check("drain_last", last, ((19 + k) % 4) == 3);
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    check("drain_valid", valid, 0);
    check("drain_fill", fill, 0);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("empty_read_fill", fill, 0);
    check("empty_read_valid", valid, 0);

    // reset mid-packet (three beats of a packet are pending in the counter)
    aresetn = 1'b0;
    step();
    check("midrst_pkt_err", pkt_err, 0);
    check("midrst_fill", fill, 0);
    aresetn = 1'b1;
    step();
    check("midrst_tready", tready, 1);

    // packets: 4 ok, TLAST on 3rd, 4 without TLAST, 4 ok
    for (int i = 0; i < 15; i++) begin
      push_beat(32'h40 + 32'(i), tl_v[i]);
      check("len_pkt_err", pkt_err, er_v[i]);
      check("len_pkt_err_nl", pkt_err_nl, 0);
      if (i == 0) begin
        check("latency_valid", valid, 1);
        check("latency_data", data, 32'h40);
      end
    end
    step();
    check("len_pulse_end", pkt_err, 0);
    check("len_fill", fill, 15);

    // every beat still read out, in order, with its TLAST
    while (exp_q.size() != 0) begin
      exp_word = exp_q.pop_front();
      check("len_read", {last, data}, exp_word);
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    check("len_read_empty", valid, 0);

    // strobe masking
`ifdef AXIS_SLAVE_STRB_MASK_EN
    exp_strb = 32'h00BB00DD;
`else
    exp_strb = 32'hAABBCCDD;
`endif
    tstrb = 4'b0101;
    push_beat(32'hAABBCCDD, 1'b0);
    tstrb = '1;
    void'(exp_q.pop_back());
    check("strb_data", data, exp_strb);
    check("strb_data_nl", data_nl, exp_strb);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("strb_pop_fill", fill, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
